// File: rtl/stream_width_upsizer_pkg.sv
// stream_width_upsizer_pkg: shared sizing helpers for the width upsizer
package stream_width_upsizer_pkg;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_width_upsizer.sv
// stream_width_upsizer: packs SCALE narrow beats little-endian into one wide beat
module stream_width_upsizer
  import stream_width_upsizer_pkg::*;
#(
  parameter int DW_IN = 16,
  parameter int SCALE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW_IN-1:0]         s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [DW_IN*SCALE-1:0]   m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i
);
  localparam int DW_OUT = DW_IN * SCALE;
  localparam int CW = cnt_width(SCALE);
  localparam int AW = DW_IN * ((SCALE > 1) ? SCALE - 1 : 1);
  localparam logic [CW-1:0] LAST = CW'(SCALE - 1);
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     acc;
  logic [DW_OUT-1:0] word;
  logic              last;
  logic              take;
  // the closing beat may only enter when the output slot is free or draining now
  always_comb begin
    last = cnt == LAST;
    s_ready_o = !last || !m_valid_o || m_ready_i;
    take = s_valid_i && s_ready_o;
    word = '0;
    for (int k = 0; k < SCALE - 1; k++) word[k*DW_IN +: DW_IN] = acc[k*DW_IN +: DW_IN];
    word[DW_OUT-1 -: DW_IN] = s_data_i;
  end
  // collect partial beats; the closing beat loads the output register directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      m_data_o <= '0;
      m_valid_o <= 1'b0;
    end else begin
      if (m_ready_i) m_valid_o <= 1'b0;
      if (take && last) begin
        m_data_o <= word;
        m_valid_o <= 1'b1;
        cnt <= '0;
      end else if (take) begin
        acc[int'(cnt)*DW_IN +: DW_IN] <= s_data_i;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_width_upsizer.sv
// tb_stream_width_upsizer: directed vector table plus streaming scoreboard runs
module tb_stream_width_upsizer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [47:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;

  stream_width_upsizer #(.DW_IN(16), .SCALE(3)) dut (
    .clk(clk), .rst(rst), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        sr;
    logic        mv;
    logic [47:0] md;
  } vec_t;

  vec_t tbl[$];
  int vecs = 0;
  int miss = 0;

  function automatic vec_t mk(logic rs, logic v, logic [15:0] d, logic r, logic sr, logic mv, logic [47:0] md);
    vec_t t;
    t.rst = rs; t.v = v; t.d = d; t.r = r; t.sr = sr; t.mv = mv; t.md = md;
    return t;
  endfunction

  // streaming scoreboard state
  logic        mon_en = 1'b0;
  logic        chk_sready = 1'b0;
  logic [47:0] part;
  logic [47:0] expq[$];
  logic [47:0] exp_w;
  logic        held = 1'b0;
  logic [47:0] held_data;
  int          mcnt = 0;
  int          nin = 0;
  int          nout = 0;
  int          sready_drops = 0;

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (held) begin
        vecs++;
        if (!(m_valid_o && m_data_o == held_data)) begin
          miss++;
          $display("FAIL hold: got mv=%b md=%h, want mv=1 md=%h", m_valid_o, m_data_o, held_data);
        end
      end
      held = m_valid_o && !m_ready_i;
      held_data = m_data_o;
      if (chk_sready && !s_ready_o) sready_drops++;
      if (s_valid_i && s_ready_o) begin
        part[mcnt*16 +: 16] = s_data_i;
        nin++;
        if (mcnt == 2) begin
          expq.push_back(part);
          mcnt = 0;
        end else mcnt++;
      end
      if (m_valid_o && m_ready_i) begin
        vecs++;
        nout++;
        if (expq.size() == 0) begin
          miss++;
          $display("FAIL stream: got unexpected word %h, want none", m_data_o);
        end else begin
          exp_w = expq.pop_front();
          if (m_data_o !== exp_w) begin
            miss++;
            $display("FAIL stream #%0d: got %h, want %h", nout, m_data_o, exp_w);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1; s_data_i = '0;
    repeat (3) step();
    rst = 1'b1;
    mcnt = 0; nin = 0; nout = 0; held = 1'b0; sready_drops = 0;
    expq.delete();
  endtask

  task automatic check_int(string name, int got, int want);
    vecs++;
    if (got != want) begin
      miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    // reset held for 10 cycles
    rst = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check_int("reset m_valid_o", int'(m_valid_o), 0);
    check_int("reset m_data_o nonzero", int'(m_data_o != 48'h0), 0);
    check_int("reset s_ready_o", int'(s_ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // idle, basic pack, backpressure, reset mid-group
    tbl.push_back(mk(1, 0, 16'hffff, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h1111, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h2222, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h3333, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 1, 48'h333322221111));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 48'h333322221111));
    tbl.push_back(mk(1, 1, 16'h0001, 0, 1, 0, 48'h333322221111));
    tbl.push_back(mk(1, 1, 16'h0002, 0, 1, 0, 48'h333322221111));
    tbl.push_back(mk(1, 1, 16'h0003, 0, 1, 0, 48'h333322221111));
    tbl.push_back(mk(1, 1, 16'h0004, 0, 1, 1, 48'h000300020001));
    tbl.push_back(mk(1, 1, 16'h0005, 0, 1, 1, 48'h000300020001));
    tbl.push_back(mk(1, 1, 16'h0006, 0, 0, 1, 48'h000300020001));
    tbl.push_back(mk(1, 1, 16'h0006, 0, 0, 1, 48'h000300020001));
    tbl.push_back(mk(1, 1, 16'h0006, 1, 1, 1, 48'h000300020001));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 48'h000600050004));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 1, 48'h000600050004));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 48'h000600050004));
    tbl.push_back(mk(1, 1, 16'haaaa, 1, 1, 0, 48'h000600050004));
    tbl.push_back(mk(1, 1, 16'hbbbb, 1, 1, 0, 48'h000600050004));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 48'h000600050004));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h0001, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h0002, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 1, 16'h0003, 1, 1, 0, 48'h0));
    tbl.push_back(mk(1, 0, 16'hffff, 1, 1, 1, 48'h000300020001));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 48'h000300020001));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; s_valid_i = tbl[i].v; s_data_i = tbl[i].d; m_ready_i = tbl[i].r;
      @(negedge clk);
      vecs++;
      if ({s_ready_o, m_valid_o, m_data_o} !== {tbl[i].sr, tbl[i].mv, tbl[i].md}) begin
        miss++;
        $display("FAIL vec%0d: got sr=%b mv=%b md=%h, want sr=%b mv=%b md=%h",
                 i, s_ready_o, m_valid_o, m_data_o, tbl[i].sr, tbl[i].mv, tbl[i].md);
      end
      @(posedge clk);
      #1;
    end

    // full throughput: valid and ready always high
    do_reset();
    mon_en = 1'b1;
    chk_sready = 1'b1;
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      s_data_i = 16'($urandom);
      step();
    end
    s_valid_i = 1'b0;
    repeat (3) step();
    chk_sready = 1'b0;
    check_int("throughput s_ready drops", sready_drops, 0);
    check_int("throughput outputs", nout, 3000);
    check_int("throughput leftover", expq.size(), 0);

    // random valid/ready rates
    mon_en = 1'b0;
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 60000 && nin < 9000; c++) begin
      s_valid_i = ($urandom_range(99) < 50);
      m_ready_i = ($urandom_range(99) < 30);
      s_data_i = 16'($urandom);
      step();
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    for (int c = 0; c < 20 && (expq.size() != 0 || m_valid_o); c++) step();
    check_int("random inputs", nin, 9000);
    check_int("random outputs", nout, 3000);
    check_int("random leftover", expq.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
